// File: rtl/rx_frame_capture.sv
// RX frame catcher: captures the head of each MAC RX frame, extracts a sequence number and reports per frame.
// Define RX_FRAME_CAPTURE_STATS_EN to add saturating good/bad/oversize frame counters.
module rx_frame_capture #(
    parameter int CAPTURE_BYTES  = 64,
    parameter int LEN_W          = 14,
    parameter int SEQ_OFFSET     = 14,
    parameter int STATUS_TIMEOUT = 16,
    localparam int AW            = $clog2(CAPTURE_BYTES)
) (
    input  logic             rx_clk,
    input  logic             reset,
    input  logic             cfg_jumbo_en,
    input  logic             cfg_no_chk_crc,
    output logic             conf_rx_en,
    output logic             conf_rx_no_chk_crc,
    output logic             conf_rx_jumbo_en,
    input  logic [7:0]       mac_rx_data,
    input  logic             mac_rx_dvld,
    input  logic             mac_rx_goodframe,
    input  logic             mac_rx_badframe,
    output logic             frm_valid,
    input  logic             frm_ready,
    output logic [LEN_W-1:0] frm_len,
    output logic             frm_good,
    output logic             frm_oversize,
    output logic [31:0]      frm_seq,
    output logic [15:0]      frm_drop_cnt,
`ifdef RX_FRAME_CAPTURE_STATS_EN
    output logic [31:0]      stat_good_cnt,
    output logic [31:0]      stat_bad_cnt,
    output logic [31:0]      stat_oversize_cnt,
`endif
    input  logic [AW-1:0]    buf_rd_addr,
    output logic [7:0]       buf_rd_data
);

    localparam int TW = $clog2(STATUS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_DATA,
        S_STATUS,
        S_REPORT,
        S_DISCARD,
        S_DISC_STATUS
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      seq_q, seq_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             frm_valid_q, frm_valid_d;
    logic [LEN_W-1:0] frm_len_q, frm_len_d;
    logic             frm_good_q, frm_good_d;
    logic             frm_oversize_q, frm_oversize_d;
    logic [31:0]      frm_seq_q, frm_seq_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             conf_rx_en_q, conf_crc_q, conf_jumbo_q;
    logic [7:0]       buf_rd_data_q;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [7:0]       wr_data;
    logic             fin, fin_good, ovs, drop;
    logic             status_seen, accept;
    logic [7:0]       rd_word;

    logic [7:0]       mem [CAPTURE_BYTES];

    assign status_seen = mac_rx_goodframe | mac_rx_badframe;
    assign accept      = frm_valid_q & frm_ready;
    // Oversize uses the saturated length and the jumbo setting the MAC actually sees.
    assign ovs         = int'(len_q) > (conf_jumbo_q ? 9018 : 1518);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        seq_d          = seq_q;
        timer_d        = timer_q;
        frm_valid_d    = frm_valid_q;
        frm_len_d      = frm_len_q;
        frm_good_d     = frm_good_q;
        frm_oversize_d = frm_oversize_q;
        frm_seq_d      = frm_seq_q;
        drop_cnt_d     = drop_cnt_q;
        wr_en          = 1'b0;
        wr_addr        = len_q[AW-1:0];
        wr_data        = mac_rx_data;
        fin            = 1'b0;
        fin_good       = 1'b0;
        drop           = 1'b0;

        if (accept) begin
            frm_valid_d = 1'b0;
        end

        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                if (mac_rx_dvld) begin
                    if (frm_valid_q) begin
                        state_d = S_DISCARD;
                    end else begin
                        state_d = S_DATA;
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        len_d   = LEN_W'(1);
                        seq_d   = (SEQ_OFFSET == 0) ? {24'd0, mac_rx_data} : 32'd0;
                    end
                end
            end
            S_DATA: begin
                if (mac_rx_dvld) begin
                    if (len_q != '1) begin
                        len_d = len_q + 1'b1;
                    end
                    if (int'(len_q) < CAPTURE_BYTES) begin
                        wr_en = 1'b1;
                    end
                    if (int'(len_q) >= SEQ_OFFSET && int'(len_q) < SEQ_OFFSET + 4) begin
                        seq_d = {seq_q[23:0], mac_rx_data};
                    end
                end else begin
                    // A status pulse coincident with the end of data is honoured immediately.
                    timer_d  = '0;
                    fin      = status_seen;
                    fin_good = mac_rx_goodframe & ~mac_rx_badframe;
                    if (!status_seen) begin
                        state_d = S_STATUS;
                    end
                end
            end
            S_STATUS: begin
                fin_good = mac_rx_goodframe & ~mac_rx_badframe;
                if (status_seen || timer_q == TW'(STATUS_TIMEOUT - 1)) begin
                    fin = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (mac_rx_dvld) begin
                    state_d = S_DISCARD;
                end else if (accept) begin
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (!mac_rx_dvld) begin
                    timer_d = '0;
                    if (status_seen) begin
                        drop = 1'b1;
                    end else begin
                        state_d = S_DISC_STATUS;
                    end
                end
            end
            S_DISC_STATUS: begin
                if (status_seen || timer_q == TW'(STATUS_TIMEOUT - 1)) begin
                    drop = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d        = S_REPORT;
            frm_valid_d    = 1'b1;
            frm_len_d      = len_q;
            frm_oversize_d = ovs;
            frm_good_d     = fin_good & ~ovs;
            frm_seq_d      = (int'(len_q) >= SEQ_OFFSET + 4) ? seq_q : 32'd0;
        end
        if (drop) begin
            state_d = S_IDLE;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_RESET;
            len_q          <= '0;
            seq_q          <= '0;
            timer_q        <= '0;
            frm_valid_q    <= 1'b0;
            frm_len_q      <= '0;
            frm_good_q     <= 1'b0;
            frm_oversize_q <= 1'b0;
            frm_seq_q      <= '0;
            drop_cnt_q     <= '0;
            conf_rx_en_q   <= 1'b0;
            conf_crc_q     <= 1'b0;
            conf_jumbo_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            seq_q          <= seq_d;
            timer_q        <= timer_d;
            frm_valid_q    <= frm_valid_d;
            frm_len_q      <= frm_len_d;
            frm_good_q     <= frm_good_d;
            frm_oversize_q <= frm_oversize_d;
            frm_seq_q      <= frm_seq_d;
            drop_cnt_q     <= drop_cnt_d;
            conf_rx_en_q   <= 1'b1;
            conf_crc_q     <= cfg_no_chk_crc;
            conf_jumbo_q   <= cfg_jumbo_en;
        end
    end

    // Capture array carries no reset so it maps onto block RAM.
    always_ff @(posedge rx_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (CAPTURE_BYTES == (1 << AW)) begin : g_rd_pow2
            assign rd_word = mem[buf_rd_addr];
        end else begin : g_rd_guard
            assign rd_word = (int'(buf_rd_addr) < CAPTURE_BYTES) ? mem[buf_rd_addr] : 8'h00;
        end
    endgenerate

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            buf_rd_data_q <= 8'h00;
        end else begin
            buf_rd_data_q <= rd_word;
        end
    end

`ifdef RX_FRAME_CAPTURE_STATS_EN
    logic [31:0] stat_good_q, stat_good_d;
    logic [31:0] stat_bad_q, stat_bad_d;
    logic [31:0] stat_ovs_q, stat_ovs_d;

    // A good-status oversize frame counts only as oversize.
    always_comb begin
        stat_good_d = stat_good_q;
        stat_bad_d  = stat_bad_q;
        stat_ovs_d  = stat_ovs_q;
        if (fin) begin
            if (fin_good && !ovs && stat_good_q != '1) begin
                stat_good_d = stat_good_q + 1'b1;
            end
            if (!fin_good && stat_bad_q != '1) begin
                stat_bad_d = stat_bad_q + 1'b1;
            end
            if (ovs && stat_ovs_q != '1) begin
                stat_ovs_d = stat_ovs_q + 1'b1;
            end
        end
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            stat_good_q <= '0;
            stat_bad_q  <= '0;
            stat_ovs_q  <= '0;
        end else begin
            stat_good_q <= stat_good_d;
            stat_bad_q  <= stat_bad_d;
            stat_ovs_q  <= stat_ovs_d;
        end
    end

    assign stat_good_cnt     = stat_good_q;
    assign stat_bad_cnt      = stat_bad_q;
    assign stat_oversize_cnt = stat_ovs_q;
`endif

    assign conf_rx_en         = conf_rx_en_q;
    assign conf_rx_no_chk_crc = conf_crc_q;
    assign conf_rx_jumbo_en   = conf_jumbo_q;
    assign frm_valid          = frm_valid_q;
    assign frm_len            = frm_len_q;
    assign frm_good           = frm_good_q;
    assign frm_oversize       = frm_oversize_q;
    assign frm_seq            = frm_seq_q;
    assign frm_drop_cnt       = drop_cnt_q;
    assign buf_rd_data        = buf_rd_data_q;

endmodule

// File: tb/tb_rx_frame_capture.sv
// Directed bench for rx_frame_capture: drives frames on the MAC RX side and checks reports and buffer.
module tb_rx_frame_capture;

    logic        rx_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_jumbo_en = 1'b0;
    logic        cfg_no_chk_crc = 1'b1;
    logic        conf_rx_en, conf_rx_no_chk_crc, conf_rx_jumbo_en;
    logic [7:0]  mac_rx_data = 8'h00;
    logic        mac_rx_dvld = 1'b0;
    logic        mac_rx_goodframe = 1'b0;
    logic        mac_rx_badframe = 1'b0;
    logic        frm_valid;
    logic        frm_ready = 1'b0;
    logic [13:0] frm_len;
    logic        frm_good, frm_oversize;
    logic [31:0] frm_seq;
    logic [15:0] frm_drop_cnt;
`ifdef RX_FRAME_CAPTURE_STATS_EN
    logic [31:0] stat_good_cnt, stat_bad_cnt, stat_oversize_cnt;
`endif
    logic [5:0]  buf_rd_addr = 6'd0;
    logic [7:0]  buf_rd_data;

    int n_checks = 0;
    int n_fail = 0;

    rx_frame_capture dut (
        .rx_clk             (rx_clk),
        .reset              (reset),
        .cfg_jumbo_en       (cfg_jumbo_en),
        .cfg_no_chk_crc     (cfg_no_chk_crc),
        .conf_rx_en         (conf_rx_en),
        .conf_rx_no_chk_crc (conf_rx_no_chk_crc),
        .conf_rx_jumbo_en   (conf_rx_jumbo_en),
        .mac_rx_data        (mac_rx_data),
        .mac_rx_dvld        (mac_rx_dvld),
        .mac_rx_goodframe   (mac_rx_goodframe),
        .mac_rx_badframe    (mac_rx_badframe),
        .frm_valid          (frm_valid),
        .frm_ready          (frm_ready),
        .frm_len            (frm_len),
        .frm_good           (frm_good),
        .frm_oversize       (frm_oversize),
        .frm_seq            (frm_seq),
        .frm_drop_cnt       (frm_drop_cnt),
`ifdef RX_FRAME_CAPTURE_STATS_EN
        .stat_good_cnt      (stat_good_cnt),
        .stat_bad_cnt       (stat_bad_cnt),
        .stat_oversize_cnt  (stat_oversize_cnt),
`endif
        .buf_rd_addr        (buf_rd_addr),
        .buf_rd_data        (buf_rd_data)
    );

    always #5 rx_clk = ~rx_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind 0: i*3+1 with DE AD BE EF at 14..17; kind 1: i*7+3; kind 2/3: i*3+1 with fixed seq bytes
    function automatic logic [7:0] byte_of(input int kind, input int i);
        logic [31:0] s;
        s = (kind == 2) ? 32'h01020304 : (kind == 3) ? 32'h11223344 : 32'hDEADBEEF;
        if (kind == 1) return 8'(i * 7 + 3);
        if (i >= 14 && i < 18) return s[8*(17-i) +: 8];
        return 8'(i * 3 + 1);
    endfunction

    task automatic send_frame(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            mac_rx_data = byte_of(kind, i);
            mac_rx_dvld = 1'b1;
            @(negedge rx_clk);
        end
        mac_rx_dvld = 1'b0;
        mac_rx_data = 8'h00;
    endtask

    task automatic pulse_status(input int gap, input bit g, input bit b);
        repeat (gap) @(negedge rx_clk);
        mac_rx_goodframe = g;
        mac_rx_badframe  = b;
        @(negedge rx_clk);
        mac_rx_goodframe = 1'b0;
        mac_rx_badframe  = 1'b0;
    endtask

    task automatic wait_report(input string tag, output int lat);
        lat = 0;
        while (frm_valid !== 1'b1 && lat < 64) begin
            @(negedge rx_clk);
            lat++;
        end
        check_val({tag, "_valid"}, 32'(frm_valid), 32'd1);
    endtask

    task automatic check_report(input string tag, input int len, input logic [31:0] seq,
                                input bit good, input bit ovs);
        check_val({tag, "_len"}, 32'(frm_len), len);
        check_val({tag, "_seq"}, frm_seq, seq);
        check_val({tag, "_good"}, 32'(frm_good), 32'(good));
        check_val({tag, "_ovs"}, 32'(frm_oversize), 32'(ovs));
    endtask

    task automatic accept_report(input string tag);
        frm_ready = 1'b1;
        @(negedge rx_clk);
        frm_ready = 1'b0;
        check_val({tag, "_accepted"}, 32'(frm_valid), 32'd0);
    endtask

    task automatic read_buf(input int addr, output logic [7:0] data);
        buf_rd_addr = 6'(addr);
        @(negedge rx_clk);
        data = buf_rd_data;
    endtask

    task automatic run_frame(input string tag, input int n, input int kind, input int gap,
                             input bit g, input bit b);
        int lat;
        send_frame(n, kind);
        pulse_status(gap, g, b);
        wait_report(tag, lat);
    endtask

    initial begin
        int lat;
        int tot;
        logic [7:0] rd;

        repeat (3) @(negedge rx_clk);
        check_val("rst_valid", 32'(frm_valid), 32'd0);
        check_val("rst_len", 32'(frm_len), 32'd0);
        check_val("rst_drop", 32'(frm_drop_cnt), 32'd0);
        check_val("rst_rx_en", 32'(conf_rx_en), 32'd0);
        check_val("rst_crc", 32'(conf_rx_no_chk_crc), 32'd0);
        reset = 1'b0;
        @(negedge rx_clk);
        check_val("conf_rx_en", 32'(conf_rx_en), 32'd1);
        check_val("conf_crc", 32'(conf_rx_no_chk_crc), 32'd1);
        check_val("conf_jumbo", 32'(conf_rx_jumbo_en), 32'd0);
        repeat (2) @(negedge rx_clk);

        // 64-byte frame, good status two cycles after data ends
        run_frame("t1", 64, 0, 2, 1'b1, 1'b0);
        check_report("t1", 64, 32'hDEADBEEF, 1'b1, 1'b0);
        accept_report("t1");
        for (int i = 0; i < 64; i++) begin
            read_buf(i, rd);
            check_val($sformatf("t1_buf%0d", i), 32'(rd), 32'(byte_of(0, i)));
        end
        check_val("t1_drop", 32'(frm_drop_cnt), 32'd0);

        // report held while a second frame arrives and is dropped
        run_frame("t2a", 20, 2, 1, 1'b1, 1'b0);
        check_report("t2a", 20, 32'h01020304, 1'b1, 1'b0);
        send_frame(30, 3);
        pulse_status(1, 1'b1, 1'b0);
        repeat (4) @(negedge rx_clk);
        check_val("t2_still_valid", 32'(frm_valid), 32'd1);
        check_val("t2_drop", 32'(frm_drop_cnt), 32'd1);
        check_report("t2_held", 20, 32'h01020304, 1'b1, 1'b0);
        accept_report("t2a");
        run_frame("t2b", 30, 3, 1, 1'b1, 1'b0);
        check_report("t2b", 30, 32'h11223344, 1'b1, 1'b0);
        accept_report("t2b");

        // 1600-byte frame without and with jumbo
        run_frame("t3a", 1600, 1, 1, 1'b1, 1'b0);
        check_report("t3a", 1600, 32'(8'(14*7+3)) << 24 | 32'(8'(15*7+3)) << 16
                     | 32'(8'(16*7+3)) << 8 | 32'(8'(17*7+3)), 1'b0, 1'b1);
        read_buf(0, rd);
        check_val("t3_buf0", 32'(rd), 32'd3);
        read_buf(63, rd);
        check_val("t3_buf63", 32'(rd), 32'd188);
        accept_report("t3a");
        cfg_jumbo_en = 1'b1;
        @(negedge rx_clk);
        check_val("t3_conf_jumbo", 32'(conf_rx_jumbo_en), 32'd1);
        run_frame("t3b", 1600, 1, 1, 1'b1, 1'b0);
        check_val("t3b_ovs", 32'(frm_oversize), 32'd0);
        check_val("t3b_good", 32'(frm_good), 32'd1);
        accept_report("t3b");
        cfg_jumbo_en = 1'b0;
        @(negedge rx_clk);
        run_frame("t3c", 1518, 1, 1, 1'b1, 1'b0);
        check_val("t3c_ovs_1518", 32'(frm_oversize), 32'd0);
        accept_report("t3c");
        run_frame("t3d", 1519, 1, 1, 1'b1, 1'b0);
        check_val("t3d_ovs_1519", 32'(frm_oversize), 32'd1);
        accept_report("t3d");

        // status timeout and simultaneous good+bad
        send_frame(20, 0);
        repeat (10) @(negedge rx_clk);
        check_val("t4_early", 32'(frm_valid), 32'd0);
        wait_report("t4", lat);
        tot = 10 + lat;
        check_val("t4_latency_ok", 32'(tot >= 16 && tot <= 18), 32'd1);
        check_report("t4", 20, 32'hDEADBEEF, 1'b0, 1'b0);
        accept_report("t4");
        run_frame("t4b", 20, 0, 1, 1'b1, 1'b1);
        check_val("t4b_good", 32'(frm_good), 32'd0);
        accept_report("t4b");

        // short frames around the sequence boundary
        run_frame("t5s17", 17, 0, 1, 1'b1, 1'b0);
        check_val("t5s17_seq", frm_seq, 32'd0);
        accept_report("t5s17");
        run_frame("t5s18", 18, 0, 1, 1'b1, 1'b0);
        check_val("t5s18_seq", frm_seq, 32'hDEADBEEF);
        accept_report("t5s18");
        run_frame("t5", 10, 0, 1, 1'b1, 1'b0);
        check_report("t5", 10, 32'd0, 1'b1, 1'b0);

        // asynchronous reset in the middle of a frame, report still pending
        for (int i = 0; i < 5; i++) begin
            mac_rx_data = byte_of(0, i);
            mac_rx_dvld = 1'b1;
            @(negedge rx_clk);
        end
        reset = 1'b1;
        #1;
        check_val("t5_rst_valid", 32'(frm_valid), 32'd0);
        check_val("t5_rst_drop", 32'(frm_drop_cnt), 32'd0);
        check_val("t5_rst_rx_en", 32'(conf_rx_en), 32'd0);
        mac_rx_dvld = 1'b0;
        mac_rx_data = 8'h00;
        repeat (2) @(negedge rx_clk);
        reset = 1'b0;
        repeat (2) @(negedge rx_clk);
        run_frame("t5r", 64, 0, 2, 1'b1, 1'b0);
        check_report("t5r", 64, 32'hDEADBEEF, 1'b1, 1'b0);
        accept_report("t5r");

`ifdef RX_FRAME_CAPTURE_STATS_EN
        reset = 1'b1;
        @(negedge rx_clk);
        check_val("t6_rst_good", stat_good_cnt, 32'd0);
        check_val("t6_rst_bad", stat_bad_cnt, 32'd0);
        check_val("t6_rst_ovs", stat_oversize_cnt, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge rx_clk);
        for (int k = 0; k < 3; k++) begin
            run_frame("t6g", 20, 0, 1, 1'b1, 1'b0);
            accept_report("t6g");
        end
        for (int k = 0; k < 2; k++) begin
            run_frame("t6b", 20, 0, 1, 1'b0, 1'b1);
            accept_report("t6b");
        end
        run_frame("t6o", 1519, 1, 1, 1'b1, 1'b0);
        accept_report("t6o");
        check_val("t6_good_cnt", stat_good_cnt, 32'd3);
        check_val("t6_bad_cnt", stat_bad_cnt, 32'd2);
        check_val("t6_ovs_cnt", stat_oversize_cnt, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
